// File: rtl/video_pattern_source.sv
// Free-running raster timing generator with 75% colour bars in 10-bit 4:2:2.
// Optional build macro VIDEO_PATTERN_CROSSHAIR_EN overlays a 1-pixel white crosshair.
module video_pattern_source #(
    parameter int H_ACTIVE = 720,
    parameter int H_BLANK  = 138,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic [19:0] o_vdat_colour,
    output logic [3:0]  o_fvht
);

    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic HB_ODD = 1'(H_BLANK % 2);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          field_q, field_d;
    logic [19:0]   colour_q, colour_d;
    logic [3:0]    fvht_q, fvht_d;

    logic          h_blank, v_blank, line_start, p_odd;
    logic [2:0]    bar;
    logic [9:0]    y_val, cb_val, cr_val, c_val;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            field_q  <= 1'b0;
            colour_q <= 20'h80040;
            fvht_q   <= 4'b0110;
        end else if (i_enable) begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            field_q  <= field_d;
            colour_q <= colour_d;
            fvht_q   <= fvht_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        field_d = field_q;
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOTAL - 1)) begin
                v_cnt_d = '0;
                field_d = ~field_q;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end
    end

    // Bar index from fixed h_cnt boundaries; the last bar keeps any remainder.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt_q >= HW'(H_BLANK + k * BAR_W)) begin
                bar = 3'(k);
            end
        end
    end

    always_comb begin
        y_val  = 10'd64;
        cb_val = 10'd512;
        cr_val = 10'd512;
        case (bar)
            3'd0: begin y_val = 10'd940; cb_val = 10'd512; cr_val = 10'd512; end
            3'd1: begin y_val = 10'd646; cb_val = 10'd176; cr_val = 10'd567; end
            3'd2: begin y_val = 10'd525; cb_val = 10'd625; cr_val = 10'd176; end
            3'd3: begin y_val = 10'd450; cb_val = 10'd289; cr_val = 10'd231; end
            3'd4: begin y_val = 10'd335; cb_val = 10'd735; cr_val = 10'd793; end
            3'd5: begin y_val = 10'd260; cb_val = 10'd399; cr_val = 10'd848; end
            3'd6: begin y_val = 10'd139; cb_val = 10'd848; cr_val = 10'd457; end
            default: begin y_val = 10'd64; cb_val = 10'd512; cr_val = 10'd512; end
        endcase
    end

    // Chroma phase follows the active pixel index, so fold in H_BLANK parity.
    always_comb begin
        h_blank    = (h_cnt_q < HW'(H_BLANK));
        v_blank    = (v_cnt_q < VW'(V_BLANK));
        line_start = (h_cnt_q == '0);
        p_odd      = h_cnt_q[0] ^ HB_ODD;
        c_val      = p_odd ? cr_val : cb_val;
        colour_d   = {c_val, y_val};
        if (h_blank || v_blank) begin
            colour_d = {10'h200, 10'h040};
        end
`ifdef VIDEO_PATTERN_CROSSHAIR_EN
        else if ((v_cnt_q == VW'(V_BLANK + V_ACTIVE / 2)) ||
                 (h_cnt_q == HW'(H_BLANK + H_ACTIVE / 2))) begin
            colour_d = {10'd512, 10'd940};
        end
`endif
        fvht_d = {field_q, v_blank, h_blank, line_start};
    end

    assign o_vdat_colour = colour_q;
    assign o_fvht        = fvht_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench for video_pattern_source: a full-size instance and a tiny-raster
// instance share stimulus; a pixel-rule reference model predicts every output cycle.
module tb_video_pattern_source;

    localparam int HB [2] = '{138, 5};
    localparam int HA [2] = '{720, 21};
    localparam int VB [2] = '{45, 3};
    localparam int VA [2] = '{480, 6};
    localparam int Y_TAB  [8] = '{940, 646, 525, 450, 335, 260, 139, 64};
    localparam int CB_TAB [8] = '{512, 176, 625, 289, 735, 399, 848, 512};
    localparam int CR_TAB [8] = '{512, 567, 176, 231, 793, 848, 457, 512};

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iEnable = 1'b1;
    logic [19:0] colour0, colour1;
    logic [3:0]  fvht0, fvht1;

    int          mh [2];
    int          mv [2];
    bit          mf [2];
    logic [23:0] mOut [2];
    logic [23:0] q0 [$];
    logic [23:0] q1 [$];
    int          nAssert = 0;
    int          nFail = 0;
    int          cycle = 0;

    always #5 clk = ~clk;

    video_pattern_source dut0 (
        .i_clk(clk), .i_reset(iReset), .i_enable(iEnable),
        .o_vdat_colour(colour0), .o_fvht(fvht0)
    );

    video_pattern_source #(.H_ACTIVE(21), .H_BLANK(5), .V_ACTIVE(6), .V_BLANK(3)) dut1 (
        .i_clk(clk), .i_reset(iReset), .i_enable(iEnable),
        .o_vdat_colour(colour1), .o_fvht(fvht1)
    );

    // Expected {F,V,H,T,C,Y} for a raster position, straight from the pixel rules.
    function automatic logic [23:0] pixelOut(int k, int h, int v, bit f);
        int y, c, p, b;
        bit hF, vF, tF;
        hF = (h < HB[k]);
        vF = (v < VB[k]);
        tF = (h == 0);
        if (hF || vF) begin
            y = 64;
            c = 512;
        end else begin
            p = h - HB[k];
            b = p / (HA[k] / 8);
            if (b > 7) b = 7;
            y = Y_TAB[b];
            c = (p % 2 == 1) ? CR_TAB[b] : CB_TAB[b];
`ifdef VIDEO_PATTERN_CROSSHAIR_EN
            if (v == VB[k] + VA[k] / 2 || h == HB[k] + HA[k] / 2) begin
                y = 940;
                c = 512;
            end
`endif
        end
        return {f, vF, hF, tF, c[9:0], y[9:0]};
    endfunction

    task automatic modelStep(int k, bit rst, bit en);
        if (rst) begin
            mOut[k] = {4'b0110, 20'h80040};
            mh[k] = 0;
            mv[k] = 0;
            mf[k] = 1'b0;
        end else if (en) begin
            mOut[k] = pixelOut(k, mh[k], mv[k], mf[k]);
            mh[k]++;
            if (mh[k] == HB[k] + HA[k]) begin
                mh[k] = 0;
                mv[k]++;
                if (mv[k] == VB[k] + VA[k]) begin
                    mv[k] = 0;
                    mf[k] = ~mf[k];
                end
            end
        end
    endtask

    task automatic applyStimulus(bit rst, bit en);
        @(negedge clk);
        iReset = rst;
        iEnable = en;
        modelStep(0, rst, en);
        modelStep(1, rst, en);
        q0.push_back(mOut[0]);
        q1.push_back(mOut[1]);
    endtask

    task automatic checkOutput(int k, logic [23:0] got, logic [23:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            if (nFail <= 20)
                $display("[TB] FAIL dut%0d cycle %0d: got fvht=%b colour=%h, expected fvht=%b colour=%h",
                         k, cycle, got[23:20], got[19:0], exp[23:20], exp[19:0]);
        end
    endtask

    task automatic runUntil(int targetV, int targetH);
        bit hit = 1'b0;
        for (int c = 0; c < 60000 && !hit; c++) begin
            if (mv[0] == targetV && mh[0] == targetH) hit = 1'b1;
            else applyStimulus(1'b0, 1'b1);
        end
        nAssert++;
        if (!hit) begin
            nFail++;
            $display("[TB] FAIL runUntil timeout: got v=%0d h=%0d, expected v=%0d h=%0d",
                     mv[0], mh[0], targetV, targetH);
        end
    endtask

    initial begin
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checkOutput(0, {fvht0, colour0}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checkOutput(1, {fvht1, colour1}, e);
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) applyStimulus(1'b1, 1'b1);
        runUntil(1, 300);
        repeat (100) applyStimulus(1'b0, 1'b0);
        runUntil(46, 0);
        runUntil(46, 500);
        applyStimulus(1'b1, 1'b1);
        repeat (2000) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 8000; i++) begin
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0);
        end
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
